// File: rtl/imm_encode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : imm_encode                                                   |
// | Brief   : Packs a signed immediate into RISC-V instruction[31:7] for   |
// |           I/S/B/J formats, flags range/alignment errors, and holds     |
// |           the result in a one-entry valid/ready output register.       |
// |           Optional feature macro: IMM_ENCODE_ERRCNT_EN (adds err_cnt). |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module imm_encode #(
  parameter int OUT_WIDTH = 25,
  parameter int IN_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  imm_in,
  input  logic [1:0]           imm_src,
  input  logic [OUT_WIDTH-1:0] base_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] instr_out,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [7:0]           err_cnt
);

  // Format encodings of imm_src
  localparam logic [1:0] C_SRC_I = 2'b00;
  localparam logic [1:0] C_SRC_S = 2'b01;
  localparam logic [1:0] C_SRC_B = 2'b10;
  localparam logic [1:0] C_SRC_J = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_out_valid;
  logic [OUT_WIDTH-1:0]   r_instr;
  logic                   r_err;

  logic                   w_accept;
  logic [OUT_WIDTH-1:0]   w_packed;
  logic                   w_err;

  // Sign-extension field above each format's top immediate bit: in range
  // only when every bit of it equals the sign bit.
  logic [IN_WIDTH-12:0]   w_hi_is;  // imm[IN_WIDTH-1:11]
  logic [IN_WIDTH-13:0]   w_hi_b;   // imm[IN_WIDTH-1:12]
  logic [IN_WIDTH-21:0]   w_hi_j;   // imm[IN_WIDTH-1:20]
  logic                   w_ok_is;
  logic                   w_ok_b;
  logic                   w_ok_j;

  assign w_hi_is = imm_in[IN_WIDTH-1:11];
  assign w_hi_b  = imm_in[IN_WIDTH-1:12];
  assign w_hi_j  = imm_in[IN_WIDTH-1:20];
  assign w_ok_is = (&w_hi_is) | ~(|w_hi_is);
  assign w_ok_b  = (&w_hi_b)  | ~(|w_hi_b);
  assign w_ok_j  = (&w_hi_j)  | ~(|w_hi_j);

  assign out_valid = r_out_valid;
  assign instr_out = r_instr;
  assign out_err   = r_err;

  // A held result can drain and be replaced in the same cycle
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Immediate bit scatter and error detection per format
  always_comb begin
    w_packed = '0;
    w_err    = 1'b0;
    case (imm_src)
      C_SRC_I: begin
        w_packed = {imm_in[11:0], base_in[12:0]};
        w_err    = !w_ok_is;
      end
      C_SRC_S: begin
        w_packed = {imm_in[11:5], base_in[17:5], imm_in[4:0]};
        w_err    = !w_ok_is;
      end
      C_SRC_B: begin
        w_packed = {imm_in[12], imm_in[10:5], base_in[17:5], imm_in[4:1], imm_in[11]};
        w_err    = !w_ok_b || imm_in[0];
      end
      C_SRC_J: begin
        w_packed = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], base_in[4:0]};
        w_err    = !w_ok_j || imm_in[0];
      end
      default: begin
        w_packed = '0;
        w_err    = 1'b0;
      end
    endcase
  end

  // Output register FSM: loads on accept, empties when drained with no new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_instr     <= w_packed;
            r_err       <= w_err;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_instr <= w_packed;
            r_err   <= w_err;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMM_ENCODE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  assign err_cnt = r_err_cnt;

  // Saturating count of accepted erroneous requests; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  logic w_unused;
  assign w_unused = ^base_in[OUT_WIDTH-1:18];
`else
  assign err_cnt = 8'd0;

  logic w_unused;
  assign w_unused = ^{base_in[OUT_WIDTH-1:18], err_clr};
`endif

endmodule
`default_nettype wire

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 25, the width of the packed instruction[31:7] field.
REQ-002 SHALL have parameter IN_WIDTH, default 32, the width of the signed immediate input.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning an encode request is present.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning a request is accepted this cycle.
REQ-007 SHALL have port imm_in, input, IN_WIDTH bits, the two's-complement immediate to pack.
REQ-008 SHALL have port imm_src, input, 2 bits, the format: 00 I, 01 S, 10 B, 11 J.
REQ-009 SHALL have port base_in, input, OUT_WIDTH bits, the instruction[31:7] carrying the non-immediate fields (rd/rs1/rs2/funct).
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the output register holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-012 SHALL have port instr_out, output, OUT_WIDTH bits, the packed instruction[31:7].
REQ-013 SHALL have port out_err, output, 1 bit, meaning the immediate was out of range or misaligned.
REQ-014 SHALL have port err_clr, input, 1 bit, a synchronous clear of err_cnt.
REQ-015 SHALL have port err_cnt, output, 8 bits, the saturating count of accepted erroneous requests.

Function
REQ-016 SHALL implement a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL drive in_ready = !out_valid || out_ready, so it can accept a new request in the same cycle the held result drains.
REQ-018 SHALL accept a request on in_valid && in_ready and present the result the next cycle (latency 1).
REQ-019 SHALL change state as follows: EMPTY->FULL on accept; FULL->EMPTY on out_ready && !in_valid; FULL stays FULL on accept while draining.
REQ-020 SHALL hold instr_out and out_err stable while out_valid && !out_ready.
REQ-021 SHALL pack I-type as out[24:13]=imm[11:0], with out[12:0]=base[12:0].
REQ-022 SHALL pack S-type as out[24:18]=imm[11:5] and out[4:0]=imm[4:0], with out[17:5]=base[17:5].
REQ-023 SHALL pack B-type as out[24]=imm[12], out[23:18]=imm[10:5], out[4:1]=imm[4:1] and out[0]=imm[11], with out[17:5]=base[17:5].
REQ-024 SHALL pack J-type as out[24]=imm[20], out[23:14]=imm[10:1], out[13]=imm[11] and out[12:5]=imm[19:12], with out[4:0]=base[4:0].
REQ-025 SHALL set out_err for I/S when imm[31:11] are not all equal.
REQ-026 SHALL set out_err for B when imm[31:12] are not all equal or imm[0]=1.
REQ-027 SHALL set out_err for J when imm[31:20] are not all equal or imm[0]=1.
REQ-028 SHALL still output the truncated packing when out_err=1.
REQ-029 SHALL increment err_cnt by 1 per accepted request with an error, saturating at 255.
REQ-030 SHALL give err_clr priority over a simultaneous increment, so err_cnt=0 the next cycle.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: FSM EMPTY, out_valid=0, instr_out=0, out_err=0, err_cnt=0.
REQ-032 SHALL discard any held result when rst_n asserts mid-transfer, with no output the cycle after release.
REQ-033 SHALL drive in_ready=1 while in reset and after release.

Configuration
REQ-034 SHALL, with IMM_ENCODE_ERRCNT_EN defined, implement the err_cnt counter and err_clr per REQ-029/030.
REQ-035 SHALL, without IMM_ENCODE_ERRCNT_EN, tie err_cnt to 0, ignore err_clr and instantiate no counter flops; all other behaviour is unchanged.

Verification
REQ-036 SHALL cover: I, imm=0xFFFFF800, base=0 -> next cycle out_valid=1, instr_out=0x1000000, out_err=0.
REQ-037 SHALL cover: I, imm=0x00000800 -> out_err=1, instr_out[24:13]=0x800, err_cnt 0->1.
REQ-038 SHALL cover: B, imm=0xFFFFF000, base=0x0003FE0 -> instr_out=0x1003FE0, out_err=0; and J, imm=0x00000001 -> out_err=1.
REQ-039 SHALL cover: out_ready=0 for 5 cycles after accept -> in_ready=0, instr_out stable; then out_ready=1 with in_valid=1 -> drain and accept in the same cycle.
REQ-040 SHALL cover: 300 erroneous requests -> err_cnt=255; err_clr together with an error -> err_cnt=0.
REQ-041 SHALL cover: rst_n=0 while FULL -> out_valid=0 immediately, err_cnt=0, in_ready=1.
